// File: rtl/ens_vote_pkg.sv
// Shared constants, width helpers and FSM state type for the ensemble vote/argmax block.
package ens_vote_pkg;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_SCORE_W     = 2;
    localparam int DEF_NUM_MEMBERS = 4;

    // Accumulator width large enough for NUM_MEMBERS maximal scores.
    function automatic int acc_width(input int score_w, input int num_members);
        return score_w + $clog2(num_members + 1);
    endfunction

    // Class index width.
    function automatic int idx_width(input int num_classes);
        return (num_classes < 2) ? 1 : $clog2(num_classes);
    endfunction

    // Beat counter width; always at least one bit.
    function automatic int cnt_width(input int num_members);
        return $clog2(num_members + 1);
    endfunction

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/ens_vote_if.sv
// Score-input and result-output handshakes of the ensemble vote block.
interface ens_vote_if
    import ens_vote_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int NUM_MEMBERS = DEF_NUM_MEMBERS
);
    localparam int ACC_W = acc_width(SCORE_W, NUM_MEMBERS);
    localparam int IDX_W = idx_width(NUM_CLASSES);

    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_CLASSES*SCORE_W-1:0] in_scores;
    logic                           out_valid;
    logic                           out_ready;
    logic [IDX_W-1:0]               out_class;
    logic [ACC_W-1:0]               out_score;

    // Upstream producer / downstream consumer side (testbench or neighbouring stages).
    modport master (
        output in_valid, in_scores, out_ready,
        input  in_ready, out_valid, out_class, out_score
    );

    // The vote block itself.
    modport slave (
        input  in_valid, in_scores, out_ready,
        output in_ready, out_valid, out_class, out_score
    );

endinterface

// File: rtl/ens_vote_acc.sv
// Bank of per-class accumulators: load on the first beat of a frame, add on the rest,
// plus a combinational indexed read port used by the sequential argmax scan.
module ens_vote_acc #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 2,
    parameter int ACC_W       = 5,
    parameter int IDX_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic                           wr_load,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [ACC_W-1:0]               rd_data
);

    logic [NUM_CLASSES-1:0][ACC_W-1:0] acc_all;

    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_lane
            logic [ACC_W-1:0] acc_q;
            logic [ACC_W-1:0] acc_d;
            logic [ACC_W-1:0] score_ext;

            assign score_ext = ACC_W'(scores[gi*SCORE_W +: SCORE_W]);

            // Next lane value: first beat overwrites, later beats accumulate.
            always_comb begin
                acc_d = acc_q;
                if (wr_en) begin
                    acc_d = wr_load ? score_ext : (acc_q + score_ext);
                end
            end

            // Lane register; reset discards any partial sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            assign acc_all[gi] = acc_q;
        end
    endgenerate

    // Read mux over valid lanes only; indices past the last class read as zero.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (rd_idx == IDX_W'(c)) begin
                rd_data = acc_all[c];
            end
        end
    end

endmodule

// File: rtl/ens_vote_argmax.sv
// Sums NUM_MEMBERS per-class score vectors, scans the sums one class per cycle for the
// argmax (ties go to the lowest index) and holds the winner on a valid/ready output.
module ens_vote_argmax
    import ens_vote_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int NUM_MEMBERS = DEF_NUM_MEMBERS
) (
    input  logic      clk,
    input  logic      rst,
    ens_vote_if.slave bus
);

    localparam int ACC_W = acc_width(SCORE_W, NUM_MEMBERS);
    localparam int IDX_W = idx_width(NUM_CLASSES);
    localparam int CNT_W = cnt_width(NUM_MEMBERS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_MEMBERS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic [ACC_W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_class_q, out_class_d;
    logic [ACC_W-1:0] out_score_q, out_score_d;

    logic             in_ready;
    logic             beat_fire;
    logic             acc_wr_en;
    logic             acc_wr_load;
    logic [ACC_W-1:0] acc_rd_data;
    logic             take_best;

    // Ready only while collecting beats, and never while reset is asserted.
    assign in_ready  = (state_q == ACCUM) && !rst;
    assign beat_fire = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_score = out_score_q;

    ens_vote_acc #(
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_W     (SCORE_W),
        .ACC_W       (ACC_W),
        .IDX_W       (IDX_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (acc_wr_en),
        .wr_load (acc_wr_load),
        .scores  (bus.in_scores),
        .rd_idx  (scan_idx_q),
        .rd_data (acc_rd_data)
    );

    // Next-state, accumulator control, scan comparator and result capture.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        scan_idx_d  = scan_idx_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_score_d = out_score_q;
        acc_wr_en   = 1'b0;
        acc_wr_load = 1'b0;
        take_best   = 1'b0;

        case (state_q)
            ACCUM: begin
                if (beat_fire) begin
                    acc_wr_en   = 1'b1;
                    acc_wr_load = (beat_cnt_q == '0);
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        scan_idx_d = '0;
                        state_d    = SCAN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end

            SCAN: begin
                // Index 0 seeds the running best; later classes must strictly beat it.
                take_best = (scan_idx_q == '0) || (acc_rd_data > best_val_q);
                if (take_best) begin
                    best_val_d = acc_rd_data;
                    best_idx_d = scan_idx_q;
                end
                if (scan_idx_q == LAST_IDX) begin
                    out_valid_d = 1'b1;
                    out_class_d = take_best ? scan_idx_q : best_idx_q;
                    out_score_d = take_best ? acc_rd_data : best_val_q;
                    state_d     = HOLD;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end

            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and output registers; reset drops any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            beat_cnt_q  <= '0;
            scan_idx_q  <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            scan_idx_q  <= scan_idx_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_score_q <= out_score_d;
        end
    end

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Self-checking bench for ens_vote_argmax: randomized frames against a sum/argmax model.
module tb_ens_vote_argmax;
    import ens_vote_pkg::*;

    localparam int NC    = 10;
    localparam int SW    = 2;
    localparam int NM    = 4;
    localparam int IN_W  = NC * SW;
    localparam int ACC_W = acc_width(SW, NM);
    localparam int IDX_W = idx_width(NC);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    ens_vote_if #(.NUM_CLASSES(NC), .SCORE_W(SW), .NUM_MEMBERS(NM)) bus ();

    ens_vote_argmax #(.NUM_CLASSES(NC), .SCORE_W(SW), .NUM_MEMBERS(NM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [IN_W-1:0] frame [NM];
    int exp_class;
    int exp_score;
    int accepted;
    int last_accept_edge;

    // Reference: plain per-class sums, then first index holding the maximum.
    task automatic compute_expected();
        int sums [NC];
        for (int c = 0; c < NC; c++) sums[c] = 0;
        for (int b = 0; b < NM; b++)
            for (int c = 0; c < NC; c++)
                sums[c] += int'(frame[b][c*SW +: SW]);
        exp_class = 0;
        exp_score = sums[0];
        for (int c = 1; c < NC; c++) begin
            if (sums[c] > exp_score) begin
                exp_class = c;
                exp_score = sums[c];
            end
        end
    endtask

    function automatic logic [IN_W-1:0] uniform_vec(input int base, input int cls, input int val);
        logic [IN_W-1:0] v;
        for (int c = 0; c < NC; c++) v[c*SW +: SW] = SW'(base);
        v[cls*SW +: SW] = SW'(val);
        return v;
    endfunction

    function automatic logic [IN_W-1:0] rand_vec();
        logic [IN_W-1:0] v;
        for (int c = 0; c < NC; c++) v[c*SW +: SW] = SW'($urandom_range(0, (1 << SW) - 1));
        return v;
    endfunction

    // Drives n_slots cycles; slot s offers the next unsent beat when vmask[s] is set.
    task automatic send_frame(input int start_idx, input int n_slots, input logic [31:0] vmask);
        int idx;
        idx = start_idx;
        accepted = 0;
        for (int s = 0; s < n_slots; s++) begin
            @(negedge clk);
            bus.in_valid  = vmask[s];
            bus.in_scores = (vmask[s] && idx < NM) ? frame[idx] : IN_W'($urandom);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                accepted++;
                idx++;
                last_accept_edge = cyc + 1;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input bit check_latency);
        int k;
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL %s_timeout: out_valid=%b expected 1", name, bus.out_valid);
        else pass_cnt++;
        if (check_latency) begin
            total_cnt++;
            if (cyc - last_accept_edge != NC)
                $display("FAIL %s_latency: got %0d cycles expected %0d", name, cyc - last_accept_edge, NC);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.out_class !== IDX_W'(exp_class))
            $display("FAIL %s_class: got %0d expected %0d", name, bus.out_class, exp_class);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_score !== ACC_W'(exp_score))
            $display("FAIL %s_score: got %0d expected %0d", name, bus.out_score, exp_score);
        else pass_cnt++;
        $display("[%0d] %s: class=%0d score=%0d (model %0d/%0d)", cyc, name,
                 bus.out_class, bus.out_score, exp_class, exp_score);
    endtask

    task automatic release_result(input string name);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL %s_release: out_valid=%b in_ready=%b expected 0/1", name, bus.out_valid, bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_scores = '1;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_class !== '0) $display("FAIL reset_out_class: got %0d expected 0", bus.out_class);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_score !== '0) $display("FAIL reset_out_score: got %0d expected 0", bus.out_score);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        else pass_cnt++;
        bus.in_valid = 1'b0;
        $display("[%0d] reset: done", cyc);
    endtask

    task automatic test_clear_winner();
        for (int b = 0; b < NM; b++) frame[b] = uniform_vec(1, 7, 3);
        compute_expected();
        send_frame(0, NM, 32'hFFFF_FFFF);
        wait_result("clear_winner", 1'b1);
        release_result("clear_winner");
    endtask

    task automatic test_tie();
        for (int b = 0; b < NM; b++) begin
            frame[b] = uniform_vec(1, 2, 2);
            frame[b][5*SW +: SW] = SW'(2);
        end
        compute_expected();
        send_frame(0, NM, 32'hFFFF_FFFF);
        wait_result("tie", 1'b1);
        release_result("tie");
        for (int b = 0; b < NM; b++) frame[b] = '0;
        compute_expected();
        send_frame(0, NM, 32'hFFFF_FFFF);
        wait_result("all_zero", 1'b1);
        release_result("all_zero");
    endtask

    task automatic test_backpressure();
        logic [IN_W-1:0] next_frame [NM];
        for (int b = 0; b < NM; b++) frame[b] = rand_vec();
        for (int b = 0; b < NM; b++) next_frame[b] = rand_vec();
        compute_expected();
        send_frame(0, NM, 32'hFFFF_FFFF);
        wait_result("bp_first", 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_scores = next_frame[0];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_class !== IDX_W'(exp_class) || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold: cycle %0d out_valid=%b out_class=%0d in_ready=%b expected 1/%0d/0",
                         i, bus.out_valid, bus.out_class, bus.in_ready, exp_class);
            else pass_cnt++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
        else pass_cnt++;
        // The held beat is taken at the coming edge as beat 0 of the next frame.
        for (int b = 0; b < NM; b++) frame[b] = next_frame[b];
        compute_expected();
        send_frame(1, NM - 1, 32'hFFFF_FFFF);
        total_cnt++;
        if (accepted != NM - 1) $display("FAIL bp_accepts: got %0d expected %0d", accepted, NM - 1);
        else pass_cnt++;
        wait_result("bp_second", 1'b1);
        release_result("bp_second");
    endtask

    task automatic test_gapped();
        for (int b = 0; b < NM; b++) frame[b] = rand_vec();
        compute_expected();
        send_frame(0, 7, 32'b1101001);
        total_cnt++;
        if (accepted != NM) $display("FAIL gapped_accepts: got %0d expected %0d", accepted, NM);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_scores = rand_vec();
            #1;
            total_cnt++;
            if (bus.in_ready !== 1'b0) $display("FAIL gapped_scan_ready: got %b expected 0", bus.in_ready);
            else pass_cnt++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_result("gapped", 1'b1);
        release_result("gapped");
    endtask

    task automatic test_reset_midframe();
        for (int b = 0; b < NM; b++) frame[b] = uniform_vec(0, 3, 3);
        send_frame(0, 2, 32'hFFFF_FFFF);
        total_cnt++;
        if (accepted != 2) $display("FAIL midreset_partial: got %0d expected 2", accepted);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL midreset_state: in_ready=%b out_valid=%b expected 0/0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
        rst = 1'b0;
        for (int b = 0; b < NM; b++) frame[b] = uniform_vec(0, 9, 2);
        compute_expected();
        send_frame(0, NM, 32'hFFFF_FFFF);
        wait_result("midreset", 1'b1);
        release_result("midreset");
    endtask

    task automatic test_random();
        logic [31:0] mask;
        int ones;
        int slots;
        for (int f = 0; f < 20; f++) begin
            for (int b = 0; b < NM; b++) frame[b] = rand_vec();
            compute_expected();
            mask  = '0;
            ones  = 0;
            slots = 0;
            while (ones < NM) begin
                mask[slots] = (slots >= 24) || ($urandom_range(0, 2) != 0);
                if (mask[slots]) ones++;
                slots++;
            end
            send_frame(0, slots, mask);
            wait_result($sformatf("random_%0d", f), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                total_cnt++;
                if (bus.out_valid !== 1'b1) $display("FAIL random_stall_valid: got %b expected 1", bus.out_valid);
                else pass_cnt++;
            end
            release_result($sformatf("random_%0d", f));
        end
    endtask

    initial begin
        bus.in_valid         = 1'b0;
        bus.in_scores        = '0;
        bus.out_ready        = 1'b0;
        last_accept_edge     = 0;
        test_reset();
        test_clear_winner();
        test_tie();
        test_backpressure();
        test_gapped();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
